// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the payload width helpers used to flatten each
// channel's fields into one vector per channel.
package axi_pkg;

   // Burst type encodings
   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   // Response encodings
   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_EXOKAY = 2'd1;
   localparam logic [1:0] RESP_SLVERR = 2'd2;
   localparam logic [1:0] RESP_DECERR = 2'd3;

   // AW/AR: addr, len(8), size(3), burst(2), lock(1), cache(4), prot(3),
   // qos(4), region(4), id
   function automatic int aw_width(input int addr_w, input int id_w);
      return addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + id_w;
   endfunction

   // W: data, strb, last
   function automatic int w_width(input int data_w);
      return data_w + data_w / 8 + 1;
   endfunction

   // B: id, resp
   function automatic int b_width(input int id_w);
      return id_w + 2;
   endfunction

   // R: id, resp, data, last
   function automatic int r_width(input int id_w, input int data_w);
      return id_w + 2 + data_w + 1;
   endfunction

endpackage

// File: rtl/axi_reg_slice_if.sv
// AXI4 bus bundle (all five channels).
// Modports:
//   master - drives AW/W/AR valid+payload and B/R ready
//   slave  - drives AW/W/AR ready and B/R valid+payload
interface axi_reg_slice_if #(
   parameter int AXI_ADDR_W = 64,
   parameter int AXI_ID_W   = 8,
   parameter int AXI_DATA_W = 64
);
   logic                      awvalid, awready;
   logic [AXI_ADDR_W-1:0]     awaddr;
   logic [7:0]                awlen;
   logic [2:0]                awsize;
   logic [1:0]                awburst;
   logic                      awlock;
   logic [3:0]                awcache;
   logic [2:0]                awprot;
   logic [3:0]                awqos;
   logic [3:0]                awregion;
   logic [AXI_ID_W-1:0]       awid;

   logic                      wvalid, wready;
   logic [AXI_DATA_W-1:0]     wdata;
   logic [AXI_DATA_W/8-1:0]   wstrb;
   logic                      wlast;

   logic                      bvalid, bready;
   logic [AXI_ID_W-1:0]       bid;
   logic [1:0]                bresp;

   logic                      arvalid, arready;
   logic [AXI_ADDR_W-1:0]     araddr;
   logic [7:0]                arlen;
   logic [2:0]                arsize;
   logic [1:0]                arburst;
   logic                      arlock;
   logic [3:0]                arcache;
   logic [2:0]                arprot;
   logic [3:0]                arqos;
   logic [3:0]                arregion;
   logic [AXI_ID_W-1:0]       arid;

   logic                      rvalid, rready;
   logic [AXI_ID_W-1:0]       rid;
   logic [1:0]                rresp;
   logic [AXI_DATA_W-1:0]     rdata;
   logic                      rlast;

   modport master (
      output awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awid,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready,
      output arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arid,
      input  arready,
      input  rvalid, rid, rresp, rdata, rlast,
      output rready
   );

   modport slave (
      input  awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awid,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready,
      input  arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arid,
      output arready,
      output rvalid, rid, rresp, rdata, rlast,
      input  rready
   );

endinterface

// File: rtl/axi_skid_buf.sv
// Two-entry skid buffer: registered valid, ready and payload on both sides.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready/in_data       sender side
//   out_valid/out_ready/out_data    receiver side
// State is {out_valid, skid_valid}: EMPTY, ONE, FULL; (0,1) never occurs.
module axi_skid_buf #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b10;
   localparam logic [1:0] ST_FULL  = 2'b11;

   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic              accept;
   logic              drain;

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b0;
         out_data   <= '0;
         skid_data  <= '0;
      end else begin
         case ({out_valid, skid_valid})
            ST_EMPTY: begin
               // also the first cycle after reset: open the input
               in_ready <= 1'b1;
               if (accept) begin
                  out_valid <= 1'b1;
                  out_data  <= in_data;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  out_data <= in_data;
               end else if (accept) begin
                  // receiver stalled: park the beat and close the input
                  skid_valid <= 1'b1;
                  skid_data  <= in_data;
                  in_ready   <= 1'b0;
               end else if (drain) begin
                  out_valid <= 1'b0;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  out_data   <= skid_data;
                  skid_valid <= 1'b0;
                  in_ready   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   a_no_illegal_state: assert property (@(posedge clk) disable iff (rst) !(!out_valid && skid_valid));

endmodule

// File: rtl/axi_reg_slice.sv
// Full-bandwidth AXI4 register slice: one skid buffer per channel, so every
// output is driven from a flop and no input reaches an output combinationally.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   s         bus facing the upstream master (slave modport)
//   m         bus facing the downstream slave (master modport)
module axi_reg_slice
   import axi_pkg::*;
#(
   parameter int AXI_ADDR_W = 64,
   parameter int AXI_ID_W   = 8,
   parameter int AXI_DATA_W = 64
) (
   input logic                   clk,
   input logic                   rst,
   axi_reg_slice_if.slave        s,
   axi_reg_slice_if.master       m
);

   localparam int AW_W = aw_width(AXI_ADDR_W, AXI_ID_W);
   localparam int W_W  = w_width(AXI_DATA_W);
   localparam int B_W  = b_width(AXI_ID_W);
   localparam int R_W  = r_width(AXI_ID_W, AXI_DATA_W);

   logic [AW_W-1:0] aw_in, aw_out, ar_in, ar_out;
   logic [W_W-1:0]  w_in, w_out;
   logic [B_W-1:0]  b_in, b_out;
   logic [R_W-1:0]  r_in, r_out;

   // Forward channels: master -> slave
   assign aw_in = {s.awaddr, s.awlen, s.awsize, s.awburst, s.awlock, s.awcache,
                   s.awprot, s.awqos, s.awregion, s.awid};
   assign {m.awaddr, m.awlen, m.awsize, m.awburst, m.awlock, m.awcache,
           m.awprot, m.awqos, m.awregion, m.awid} = aw_out;

   assign w_in = {s.wdata, s.wstrb, s.wlast};
   assign {m.wdata, m.wstrb, m.wlast} = w_out;

   assign ar_in = {s.araddr, s.arlen, s.arsize, s.arburst, s.arlock, s.arcache,
                   s.arprot, s.arqos, s.arregion, s.arid};
   assign {m.araddr, m.arlen, m.arsize, m.arburst, m.arlock, m.arcache,
           m.arprot, m.arqos, m.arregion, m.arid} = ar_out;

   // Reverse channels: slave -> master
   assign b_in = {m.bid, m.bresp};
   assign {s.bid, s.bresp} = b_out;

   assign r_in = {m.rid, m.rresp, m.rdata, m.rlast};
   assign {s.rid, s.rresp, s.rdata, s.rlast} = r_out;

   axi_skid_buf #(.DATA_W(AW_W)) u_aw (
      .clk(clk), .rst(rst),
      .in_valid(s.awvalid), .in_ready(s.awready), .in_data(aw_in),
      .out_valid(m.awvalid), .out_ready(m.awready), .out_data(aw_out)
   );

   axi_skid_buf #(.DATA_W(W_W)) u_w (
      .clk(clk), .rst(rst),
      .in_valid(s.wvalid), .in_ready(s.wready), .in_data(w_in),
      .out_valid(m.wvalid), .out_ready(m.wready), .out_data(w_out)
   );

   axi_skid_buf #(.DATA_W(AW_W)) u_ar (
      .clk(clk), .rst(rst),
      .in_valid(s.arvalid), .in_ready(s.arready), .in_data(ar_in),
      .out_valid(m.arvalid), .out_ready(m.arready), .out_data(ar_out)
   );

   axi_skid_buf #(.DATA_W(B_W)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(m.bvalid), .in_ready(m.bready), .in_data(b_in),
      .out_valid(s.bvalid), .out_ready(s.bready), .out_data(b_out)
   );

   axi_skid_buf #(.DATA_W(R_W)) u_r (
      .clk(clk), .rst(rst),
      .in_valid(m.rvalid), .in_ready(m.rready), .in_data(r_in),
      .out_valid(s.rvalid), .out_ready(s.rready), .out_data(r_out)
   );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Self-checking bench for axi_reg_slice: the bench acts as upstream master
// (bus "up") and downstream slave (bus "dn"); per-channel scoreboard queues.
module tb_axi_reg_slice;
   import axi_pkg::*;

   localparam int AXI_ADDR_W = 64;
   localparam int AXI_ID_W   = 8;
   localparam int AXI_DATA_W = 64;
   localparam int AWW = aw_width(AXI_ADDR_W, AXI_ID_W);
   localparam int WW  = w_width(AXI_DATA_W);
   localparam int BW  = b_width(AXI_ID_W);
   localparam int RW  = r_width(AXI_ID_W, AXI_DATA_W);
   localparam int TMO = 1000;
   localparam int N_RAND = 2000;
   localparam logic [63:0] RBASE = 64'h1000_0000_0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_reg_slice_if #(.AXI_ADDR_W(AXI_ADDR_W), .AXI_ID_W(AXI_ID_W), .AXI_DATA_W(AXI_DATA_W)) up ();
   axi_reg_slice_if #(.AXI_ADDR_W(AXI_ADDR_W), .AXI_ID_W(AXI_ID_W), .AXI_DATA_W(AXI_DATA_W)) dn ();

   axi_reg_slice #(.AXI_ADDR_W(AXI_ADDR_W), .AXI_ID_W(AXI_ID_W), .AXI_DATA_W(AXI_DATA_W)) dut (
      .clk(clk), .rst(rst), .s(up), .m(dn)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // packed views of every channel on both buses
   logic [AWW-1:0] up_aw, dn_aw, up_ar, dn_ar;
   logic [WW-1:0]  up_w, dn_w;
   logic [BW-1:0]  up_b, dn_b;
   logic [RW-1:0]  up_r, dn_r;
   logic [9:0]     ctl_vec;
   logic           out_x;

   assign up_aw = {up.awaddr, up.awlen, up.awsize, up.awburst, up.awlock, up.awcache, up.awprot, up.awqos, up.awregion, up.awid};
   assign dn_aw = {dn.awaddr, dn.awlen, dn.awsize, dn.awburst, dn.awlock, dn.awcache, dn.awprot, dn.awqos, dn.awregion, dn.awid};
   assign up_ar = {up.araddr, up.arlen, up.arsize, up.arburst, up.arlock, up.arcache, up.arprot, up.arqos, up.arregion, up.arid};
   assign dn_ar = {dn.araddr, dn.arlen, dn.arsize, dn.arburst, dn.arlock, dn.arcache, dn.arprot, dn.arqos, dn.arregion, dn.arid};
   assign up_w  = {up.wdata, up.wstrb, up.wlast};
   assign dn_w  = {dn.wdata, dn.wstrb, dn.wlast};
   assign up_b  = {up.bid, up.bresp};
   assign dn_b  = {dn.bid, dn.bresp};
   assign up_r  = {up.rid, up.rresp, up.rdata, up.rlast};
   assign dn_r  = {dn.rid, dn.rresp, dn.rdata, dn.rlast};
   assign ctl_vec = {up.awready, up.wready, up.arready, up.bvalid, up.rvalid,
                     dn.awvalid, dn.wvalid, dn.arvalid, dn.bready, dn.rready};
   assign out_x = $isunknown({ctl_vec, dn_aw, dn_w, dn_ar, up_b, up_r});

   // ---------------- drivers ----------------
   task automatic drive_aw(input logic [AWW-1:0] p);
      {up.awaddr, up.awlen, up.awsize, up.awburst, up.awlock, up.awcache, up.awprot, up.awqos, up.awregion, up.awid} = p;
   endtask
   task automatic drive_ar(input logic [AWW-1:0] p);
      {up.araddr, up.arlen, up.arsize, up.arburst, up.arlock, up.arcache, up.arprot, up.arqos, up.arregion, up.arid} = p;
   endtask
   task automatic drive_w(input logic [WW-1:0] p);
      {up.wdata, up.wstrb, up.wlast} = p;
   endtask
   task automatic drive_b(input logic [BW-1:0] p);
      {dn.bid, dn.bresp} = p;
   endtask
   task automatic drive_r(input logic [RW-1:0] p);
      {dn.rid, dn.rresp, dn.rdata, dn.rlast} = p;
   endtask

   task automatic put_aw(input logic [AWW-1:0] p);
      int t = 0;
      drive_aw(p); up.awvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!up.awready && t < TMO);
      if (!up.awready) chk("aw_timeout", 128'(0), 128'(1));
      tick(); up.awvalid = 1'b0;
   endtask
   task automatic put_ar(input logic [AWW-1:0] p);
      int t = 0;
      drive_ar(p); up.arvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!up.arready && t < TMO);
      if (!up.arready) chk("ar_timeout", 128'(0), 128'(1));
      tick(); up.arvalid = 1'b0;
   endtask
   task automatic put_w(input logic [WW-1:0] p);
      int t = 0;
      drive_w(p); up.wvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!up.wready && t < TMO);
      if (!up.wready) chk("w_timeout", 128'(0), 128'(1));
      tick(); up.wvalid = 1'b0;
   endtask
   task automatic put_b(input logic [BW-1:0] p);
      int t = 0;
      drive_b(p); dn.bvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!dn.bready && t < TMO);
      if (!dn.bready) chk("b_timeout", 128'(0), 128'(1));
      tick(); dn.bvalid = 1'b0;
   endtask
   task automatic put_r(input logic [RW-1:0] p);
      int t = 0;
      drive_r(p); dn.rvalid = 1'b1;
      do begin @(negedge clk); t++; end while (!dn.rready && t < TMO);
      if (!dn.rready) chk("r_timeout", 128'(0), 128'(1));
      tick(); dn.rvalid = 1'b0;
   endtask

   // ---------------- scoreboard / monitors ----------------
   logic [AWW-1:0] q_aw[$], q_ar[$];
   logic [WW-1:0]  q_w[$];
   logic [BW-1:0]  q_b[$];
   logic [RW-1:0]  q_r[$];

   logic aw_st, w_st, ar_st, b_st, r_st;
   logic [AWW-1:0] aw_hd, ar_hd;
   logic [WW-1:0]  w_hd;
   logic [BW-1:0]  b_hd;
   logic [RW-1:0]  r_hd;

   always @(negedge clk) begin
      if (rst) begin
         aw_st = 1'b0; w_st = 1'b0; ar_st = 1'b0; b_st = 1'b0; r_st = 1'b0;
      end else begin
         // AW
         if (aw_st) begin
            chk("aw_hold_valid", 128'(dn.awvalid), 128'(1));
            chk("aw_hold_data", 128'(dn_aw), 128'(aw_hd));
         end
         aw_st = dn.awvalid & ~dn.awready; aw_hd = dn_aw;
         if (dn.awvalid && dn.awready) begin
            if (q_aw.size() == 0) chk("aw_extra_beat", 128'(1), 128'(0));
            else chk("aw_order", 128'(dn_aw), 128'(q_aw.pop_front()));
         end
         if (up.awvalid && up.awready) q_aw.push_back(up_aw);
         // W
         if (w_st) begin
            chk("w_hold_valid", 128'(dn.wvalid), 128'(1));
            chk("w_hold_data", 128'(dn_w), 128'(w_hd));
         end
         w_st = dn.wvalid & ~dn.wready; w_hd = dn_w;
         if (dn.wvalid && dn.wready) begin
            if (q_w.size() == 0) chk("w_extra_beat", 128'(1), 128'(0));
            else chk("w_order", 128'(dn_w), 128'(q_w.pop_front()));
         end
         if (up.wvalid && up.wready) q_w.push_back(up_w);
         // AR
         if (ar_st) begin
            chk("ar_hold_valid", 128'(dn.arvalid), 128'(1));
            chk("ar_hold_data", 128'(dn_ar), 128'(ar_hd));
         end
         ar_st = dn.arvalid & ~dn.arready; ar_hd = dn_ar;
         if (dn.arvalid && dn.arready) begin
            if (q_ar.size() == 0) chk("ar_extra_beat", 128'(1), 128'(0));
            else chk("ar_order", 128'(dn_ar), 128'(q_ar.pop_front()));
         end
         if (up.arvalid && up.arready) q_ar.push_back(up_ar);
         // B (reverse)
         if (b_st) begin
            chk("b_hold_valid", 128'(up.bvalid), 128'(1));
            chk("b_hold_data", 128'(up_b), 128'(b_hd));
         end
         b_st = up.bvalid & ~up.bready; b_hd = up_b;
         if (up.bvalid && up.bready) begin
            if (q_b.size() == 0) chk("b_extra_beat", 128'(1), 128'(0));
            else chk("b_order", 128'(up_b), 128'(q_b.pop_front()));
         end
         if (dn.bvalid && dn.bready) q_b.push_back(dn_b);
         // R (reverse)
         if (r_st) begin
            chk("r_hold_valid", 128'(up.rvalid), 128'(1));
            chk("r_hold_data", 128'(up_r), 128'(r_hd));
         end
         r_st = up.rvalid & ~up.rready; r_hd = up_r;
         if (up.rvalid && up.rready) begin
            if (q_r.size() == 0) chk("r_extra_beat", 128'(1), 128'(0));
            else chk("r_order", 128'(up_r), 128'(q_r.pop_front()));
         end
         if (dn.rvalid && dn.rready) q_r.push_back(dn_r);
      end
   end

   // ---------------- stimulus ----------------
   int  wt;
   logic done;
   logic [127:0] rv_aw, rv_w, rv_ar, rv_b, rv_r;

   initial begin
      up.awvalid = 1'b0; up.wvalid = 1'b0; up.arvalid = 1'b0; up.bready = 1'b0; up.rready = 1'b0;
      dn.awready = 1'b0; dn.wready = 1'b0; dn.arready = 1'b0; dn.bvalid = 1'b0; dn.rvalid = 1'b0;
      drive_aw('0); drive_ar('0); drive_w('0); drive_b('0); drive_r('0);
      done = 1'b0;

      // reset with a pending AW request
      rst = 1'b1; up.awvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_valid_ready", 128'(ctl_vec), 128'(0));
         chk("rst_payload", 128'(dn_aw), 128'(0));
      end
      rst = 1'b0;
      tick();
      chk("post_rst_awready", 128'(up.awready), 128'(1));
      chk("post_rst_awvalid", 128'(dn.awvalid), 128'(0));
      up.awvalid = 1'b0;

      // single write
      dn.awready = 1'b1; dn.wready = 1'b1; dn.arready = 1'b1; up.bready = 1'b1; up.rready = 1'b1;
      drive_aw({64'h8000_0000, 8'd0, 3'd3, BURST_INCR, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 8'h05});
      drive_w({64'hDEAD_BEEF_0000_1111, 8'hFF, 1'b1});
      up.awvalid = 1'b1; up.wvalid = 1'b1;
      tick();
      up.awvalid = 1'b0; up.wvalid = 1'b0;
      chk("wr_awvalid", 128'(dn.awvalid), 128'(1));
      chk("wr_awaddr", 128'(dn.awaddr), 128'(64'h8000_0000));
      chk("wr_awid", 128'(dn.awid), 128'(8'h05));
      chk("wr_awlen", 128'(dn.awlen), 128'(0));
      chk("wr_wvalid", 128'(dn.wvalid), 128'(1));
      chk("wr_wdata", 128'(dn.wdata), 128'(64'hDEAD_BEEF_0000_1111));
      chk("wr_wstrb", 128'(dn.wstrb), 128'(8'hFF));
      chk("wr_wlast", 128'(dn.wlast), 128'(1));
      tick();
      chk("wr_aw_drained", 128'(dn.awvalid), 128'(0));
      drive_b({8'h05, RESP_OKAY});
      dn.bvalid = 1'b1;
      tick();
      dn.bvalid = 1'b0;
      chk("wr_bvalid", 128'(up.bvalid), 128'(1));
      chk("wr_bid", 128'(up.bid), 128'(8'h05));
      chk("wr_bresp", 128'(up.bresp), 128'(RESP_OKAY));
      tick();

      // streaming read, 16 beats
      fork
         begin
            put_ar({64'h0000_4000, 8'd15, 3'd3, BURST_INCR, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 8'h21});
            for (int k = 0; k < 16; k++)
               put_r({8'h21, RESP_OKAY, RBASE + 64'(k), k == 15});
         end
         begin
            wt = 0;
            @(negedge clk);
            while (!up.rvalid && wt < TMO) begin @(negedge clk); wt++; end
            for (int k = 0; k < 16; k++) begin
               chk("rd_stream_valid", 128'(up.rvalid), 128'(1));
               chk("rd_stream_data", 128'(up.rdata), 128'(RBASE + 64'(k)));
               chk("rd_stream_last", 128'(up.rlast), 128'(k == 15));
               @(negedge clk);
            end
         end
      join
      repeat (3) tick();

      // back-pressure on R
      up.rready = 1'b0;
      put_r({8'h33, RESP_OKAY, 64'hAAAA_0000_0000_000A, 1'b0});
      chk("bp_rready_after_a", 128'(dn.rready), 128'(1));
      put_r({8'h33, RESP_OKAY, 64'hBBBB_0000_0000_000B, 1'b0});
      chk("bp_rready_after_b", 128'(dn.rready), 128'(0));
      drive_r({8'h33, RESP_OKAY, 64'hCCCC_0000_0000_000C, 1'b1});
      dn.rvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_stall_valid", 128'(up.rvalid), 128'(1));
         chk("bp_stall_data", 128'(up.rdata), 128'(64'hAAAA_0000_0000_000A));
         chk("bp_stall_rready", 128'(dn.rready), 128'(0));
      end
      tick();
      up.rready = 1'b1;
      wt = 0;
      do begin @(negedge clk); wt++; end while (!dn.rready && wt < TMO);
      if (!dn.rready) chk("bp_c_timeout", 128'(0), 128'(1));
      tick();
      dn.rvalid = 1'b0;
      repeat (4) tick();
      chk("bp_r_drained", 128'(q_r.size()), 128'(0));

      // downstream that never accepts AW
      dn.awready = 1'b0;
      put_aw({64'h0000_1000, 8'd0, 3'd3, BURST_INCR, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 8'h01});
      put_aw({64'h0000_2000, 8'd0, 3'd3, BURST_INCR, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 8'h02});
      drive_aw({64'h0000_3000, 8'd0, 3'd3, BURST_INCR, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 8'h03});
      up.awvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("ds_awready", 128'(up.awready), 128'(0));
         chk("ds_awvalid", 128'(dn.awvalid), 128'(1));
         chk("ds_no_x", 128'(out_x), 128'(0));
      end
      chk("ds_queued", 128'(q_aw.size()), 128'(2));
      tick();
      dn.awready = 1'b1;
      wt = 0;
      do begin @(negedge clk); wt++; end while (!up.awready && wt < TMO);
      if (!up.awready) chk("ds_release_timeout", 128'(0), 128'(1));
      tick();
      up.awvalid = 1'b0;
      repeat (5) tick();

      // random valid/ready on all channels
      fork
         begin
            fork
               begin
                  for (int i = 0; i < N_RAND; i++) begin
                     rv_aw = rnd();
                     repeat ($urandom_range(1)) tick();
                     put_aw(rv_aw[AWW-1:0]);
                  end
               end
               begin
                  for (int i = 0; i < N_RAND; i++) begin
                     rv_w = rnd();
                     repeat ($urandom_range(1)) tick();
                     put_w(rv_w[WW-1:0]);
                  end
               end
               begin
                  for (int i = 0; i < N_RAND; i++) begin
                     rv_ar = rnd();
                     repeat ($urandom_range(1)) tick();
                     put_ar(rv_ar[AWW-1:0]);
                  end
               end
               begin
                  for (int i = 0; i < N_RAND; i++) begin
                     rv_b = rnd();
                     repeat ($urandom_range(1)) tick();
                     put_b(rv_b[BW-1:0]);
                  end
               end
               begin
                  for (int i = 0; i < N_RAND; i++) begin
                     rv_r = rnd();
                     repeat ($urandom_range(1)) tick();
                     put_r(rv_r[RW-1:0]);
                  end
               end
            join
            done = 1'b1;
         end
         begin
            while (!done) begin
               tick();
               dn.awready = 1'($urandom_range(1));
               dn.wready  = 1'($urandom_range(1));
               dn.arready = 1'($urandom_range(1));
               up.bready  = 1'($urandom_range(1));
               up.rready  = 1'($urandom_range(1));
            end
         end
      join
      dn.awready = 1'b1; dn.wready = 1'b1; dn.arready = 1'b1; up.bready = 1'b1; up.rready = 1'b1;
      repeat (20) tick();
      chk("sb_all_drained", 128'(q_aw.size() + q_w.size() + q_ar.size() + q_b.size() + q_r.size()), 128'(0));
      chk("idle_no_x", 128'(out_x), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
